axi_lite_timer: RTL and testbench

Memory-mapped 32-bit timer/compare peripheral on the AXI4-Lite side of the CPU's handshake-to-AXI bridge, next to the UART on the same AXI port set. Provides a free-running or auto-reloading counter with a prescaler, a compare match flag and a level interrupt. The CPU reaches it through the AXI address window, offset bits [3:2] selecting one of four registers.

---
 rtl/axi_lite_timer.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_lite_timer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_timer.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_timer
// Description : AXI4-Lite memory-mapped 32-bit timer/compare peripheral.
//               A prescaled counter with optional auto-reload, a sticky
//               compare-match flag (write-1-to-clear) and a level interrupt.
//               Register map (offset bits [3:2]):
//                 0x0 CTRL    bit0 enable, bit1 auto_reload, bit2 irq_en
//                 0x4 STATUS  bit0 match (W1C)
//                 0x8 COUNT   counter value, write loads the counter
//                 0xC COMPARE compare value, resets to all ones
// Ports       : clk_i/rst_i (async active-low reset)
//               AR/R channel : araddr_i, arvalid_i, arready_o, rdata_o,
//                              rresp_o, rlast_o, rvalid_o, rready_i
//               AW/W/B chan. : awaddr_i, awvalid_i, awready_o, wdata_i,
//                              wvalid_i, wready_o, wlast_i, bresp_o,
//                              bvalid_o, bready_i
//               irq_o        : STATUS.match AND CTRL.irq_en
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic [3:0]  awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic        wlast_i,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic        irq_o
);

  localparam int unsigned  PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_COUNT   = 2'd2;
  localparam logic [1:0] A_COMPARE = 2'd3;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Timer state
  logic [2:0]    ctrl_q,    ctrl_d;
  logic          match_q,   match_d;
  logic [31:0]   count_q,   count_d;
  logic [31:0]   compare_q, compare_d;
  logic [PW-1:0] presc_q,   presc_d;

  // Read channel state
  rd_state_e     rstate_q;
  logic [31:0]   rdata_q;
  logic          rvalid_q;

  // Write channel state
  logic          aw_held_q;
  logic [1:0]    awaddr_q;
  logic          w_held_q;
  logic [31:0]   wdata_q;
  logic          bvalid_q;

  logic          aw_hs, w_hs, wr_commit;
  logic [1:0]    wr_sel;
  logic [31:0]   wr_data;
  logic          tick, hit;
  logic [31:0]   rd_mux;

  // Address low bits and wlast carry no information for a full-word slave.
  logic          unused_bits;
  assign unused_bits = ^{araddr_i[1:0], awaddr_i[1:0], wlast_i};

  // --------------------------------------------------------------------------
  // Handshake outputs. Readies are gated by reset so every output except
  // rlast_o reads 0 while reset is asserted.
  // --------------------------------------------------------------------------
  assign arready_o = rst_i & (rstate_q == R_IDLE);
  assign awready_o = rst_i & ~aw_held_q & ~bvalid_q;
  assign wready_o  = rst_i & ~w_held_q  & ~bvalid_q;
  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign rresp_o   = 2'b00;
  assign rlast_o   = 1'b1;
  assign bresp_o   = 2'b00;
  assign bvalid_o  = bvalid_q;
  assign irq_o     = match_q & ctrl_q[2];

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i  & wready_o;

  // The write commits on the edge that completes the later of the two
  // handshakes; the already-held half is taken from its capture register.
  assign wr_commit = (aw_hs | w_hs) & (aw_hs | aw_held_q) & (w_hs | w_held_q);
  assign wr_sel    = aw_held_q ? awaddr_q : awaddr_i[3:2];
  assign wr_data   = w_held_q  ? wdata_q  : wdata_i;

  assign tick = ctrl_q[0] & (presc_q == PS_LAST);
  assign hit  = (count_q == compare_q);

  // --------------------------------------------------------------------------
  // Next-state logic for the timer registers
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_d    = ctrl_q;
    match_d   = match_q;
    count_d   = count_q;
    compare_d = compare_q;
    presc_d   = presc_q;

    if (!ctrl_q[0]) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (tick) begin
      count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    end

    if (wr_commit) begin
      case (wr_sel)
        A_CTRL: begin
          ctrl_d = wr_data[2:0];
          // Disabling restarts the prescaler phase immediately.
          if (!wr_data[0]) begin
            presc_d = '0;
          end
        end
        A_STATUS: begin
          if (wr_data[0]) begin
            match_d = 1'b0;
          end
        end
        A_COUNT:   count_d   = wr_data;   // CPU load overrides a tick
        A_COMPARE: compare_d = wr_data;
        default:   ;
      endcase
    end

    // A new match has priority over a simultaneous W1C.
    if (tick && hit) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= 3'b000;
      match_q   <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      presc_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      presc_q   <= presc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write channel: independent address/data capture and response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= 2'b00;
      w_held_q  <= 1'b0;
      wdata_q   <= 32'd0;
      bvalid_q  <= 1'b0;
    end else begin
      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= awaddr_i[3:2];
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= wdata_i;
        end
        if (bvalid_q && bready_i) begin
          bvalid_q <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read channel FSM
  // --------------------------------------------------------------------------
  always_comb begin
    rd_mux = 32'd0;
    case (araddr_i[3:2])
      A_CTRL:    rd_mux = {29'd0, ctrl_q};
      A_STATUS:  rd_mux = {31'd0, match_q};
      A_COUNT:   rd_mux = count_q;
      A_COMPARE: rd_mux = compare_q;
      default:   rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rstate_q <= R_IDLE;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (arvalid_i) begin
            rdata_q  <= rd_mux;
            rvalid_q <= 1'b1;
            rstate_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready_i) begin
            rvalid_q <= 1'b0;
            rstate_q <= R_IDLE;
          end
        end
        default: begin
          rvalid_q <= 1'b0;
          rstate_q <= R_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_timer
// Description : Self-checking bench for axi_lite_timer. Two instances
//               (PRESCALE=1 and PRESCALE=4) share all inputs; a select
//               chooses whose outputs are observed. Read expectations are
//               queued at the address handshake and popped at rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  araddr = 4'd0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic [3:0]  awaddr = 4'd0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b0;
  logic        sel4 = 1'b0;

  logic        arready1, rvalid1, rlast1, awready1, wready1, bvalid1, irq1;
  logic        arready4, rvalid4, rlast4, awready4, wready4, bvalid4, irq4;
  logic [31:0] rdata1, rdata4;
  logic [1:0]  rresp1, rresp4, bresp1, bresp4;

  logic        arready, rvalid, rlast, awready, wready, bvalid, irq;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  assign arready = sel4 ? arready4 : arready1;
  assign rvalid  = sel4 ? rvalid4  : rvalid1;
  assign rlast   = sel4 ? rlast4   : rlast1;
  assign awready = sel4 ? awready4 : awready1;
  assign wready  = sel4 ? wready4  : wready1;
  assign bvalid  = sel4 ? bvalid4  : bvalid1;
  assign irq     = sel4 ? irq4     : irq1;
  assign rdata   = sel4 ? rdata4   : rdata1;
  assign rresp   = sel4 ? rresp4   : rresp1;

  axi_lite_timer #(.PRESCALE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready1),
    .rdata_o(rdata1), .rresp_o(rresp1), .rlast_o(rlast1),
    .rvalid_o(rvalid1), .rready_i(rready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready1),
    .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(wready1), .wlast_i(1'b1),
    .bresp_o(bresp1), .bvalid_o(bvalid1), .bready_i(bready),
    .irq_o(irq1)
  );

  axi_lite_timer #(.PRESCALE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready4),
    .rdata_o(rdata4), .rresp_o(rresp4), .rlast_o(rlast4),
    .rvalid_o(rvalid4), .rready_i(rready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready4),
    .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(wready4), .wlast_i(1'b1),
    .bresp_o(bresp4), .bvalid_o(bvalid4), .bready_i(bready),
    .irq_o(irq4)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] scb[$];
  int wr_edge = 0;

  // Reference timer model: state after edge cyc, given the edge at which the
  // counter was last loaded/enabled (prescaler phase 0 after that edge).
  logic [31:0] m_start = 32'd0;
  logic [31:0] m_cmp   = 32'hFFFF_FFFF;
  int          m_edge  = 0;
  int          m_ps    = 1;
  int          m_clr   = 0;
  bit          m_auto  = 1'b0;
  bit          m_irqen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void mdl(output logic [31:0] c, output logic m);
    int n;
    int tedge;
    c = m_start;
    m = 1'b0;
    n = (cyc >= m_edge) ? (cyc - m_edge) / m_ps : 0;
    for (int i = 0; i < n; i++) begin
      tedge = m_edge + (i + 1) * m_ps;
      if (c == m_cmp) begin
        if (tedge >= m_clr) m = 1'b1;
        c = m_auto ? 32'd0 : c + 32'd1;
      end else begin
        c = c + 32'd1;
      end
    end
  endfunction

  function automatic logic sig_val(input int sig);
    case (sig)
      0:       return arready;
      1:       return rvalid;
      2:       return bvalid;
      3:       return awready;
      4:       return wready;
      default: return awready & wready;
    endcase
  endfunction

  task automatic wait_for(input int sig, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!sig_val(sig) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!sig_val(sig)) check_eq({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_in,
                          input bit use_mdl, input string tag);
    logic [31:0] e, c;
    logic m;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    wait_for(0, "arready");
    e = exp_in;
    if (use_mdl) begin
      mdl(c, m);
      e = (addr[3:2] == 2'd2) ? c : {31'd0, m};
    end
    scb.push_back(e);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_for(1, "rvalid");
    if (scb.size() > 0) check_eq(tag, rdata, scb.pop_front());
    check_eq("rresp", {30'd0, rresp}, 32'd0);
    check_eq("rlast", {31'd0, rlast}, 32'd1);
    @(posedge clk); #1;
  endtask

  // mode 0: address first, 1: data first, 2: both together
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input int mode);
    @(posedge clk); #1;
    awaddr = addr; wdata = data; bready = 1'b1;
    case (mode)
      0: begin
        awvalid = 1'b1;
        wait_for(3, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0;
        check_eq("no_early_b_aw", {31'd0, bvalid}, 32'd0);
        wvalid = 1'b1;
        wait_for(4, "wready");
        @(posedge clk); #1;
        wvalid = 1'b0;
      end
      1: begin
        wvalid = 1'b1;
        wait_for(4, "wready");
        @(posedge clk); #1;
        wvalid = 1'b0;
        check_eq("no_early_b_w", {31'd0, bvalid}, 32'd0);
        awvalid = 1'b1;
        wait_for(3, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0;
      end
      default: begin
        awvalid = 1'b1; wvalid = 1'b1;
        wait_for(5, "both_ready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
      end
    endcase
    wait_for(2, "bvalid");
    wr_edge = cyc;
    if (mode != 2) check_eq("awready_in_b", {31'd0, awready | wready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bvalid_drop", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic irq_span(input int ncyc, input string tag);
    logic [31:0] c;
    logic m;
    repeat (ncyc) begin
      @(negedge clk);
      mdl(c, m);
      check_eq(tag, {31'd0, irq}, {31'd0, m & m_irqen});
    end
  endtask

  // Stops the counter and sets up the model for a fresh run at the CTRL edge.
  task automatic start_timer(input logic [31:0] start, input logic [31:0] cmp,
                             input logic [2:0] ctrl, input int ps);
    axi_write(4'h0, 32'd0, 2);
    axi_write(4'h8, start, 2);
    axi_write(4'hC, cmp, 2);
    axi_write(4'h4, 32'd1, 2);
    axi_write(4'h0, {29'd0, ctrl}, 2);
    m_start = start; m_cmp = cmp; m_edge = wr_edge; m_ps = ps;
    m_clr = 0; m_auto = ctrl[1]; m_irqen = ctrl[2];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check_eq("rst_arready", {31'd0, arready}, 32'd0);
    check_eq("rst_rlast", {31'd0, rlast}, 32'd1);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset values
    axi_read(4'h0, 32'd0, 0, "rst_ctrl");
    axi_read(4'h4, 32'd0, 0, "rst_status");
    axi_read(4'h8, 32'd0, 0, "rst_count");
    axi_read(4'hC, 32'hFFFF_FFFF, 0, "rst_compare");

    // Write ordering
    for (int md = 0; md < 3; md++) begin
      axi_write(4'hC, 32'd5 + 32'(md) * 32'h10, md);
      axi_read(4'hC, 32'd5 + 32'(md) * 32'h10, 0, "cmp_readback");
    end

    // One-shot match, PRESCALE=1
    sel4 = 1'b0;
    start_timer(32'd0, 32'd5, 3'b101, 1);
    irq_span(10, "oneshot_irq");
    axi_read(4'h8, 32'd0, 1, "oneshot_count");
    axi_read(4'h4, 32'd0, 1, "oneshot_status");
    axi_write(4'h4, 32'd1, 2);
    m_clr = wr_edge;
    irq_span(3, "w1c_irq");
    axi_read(4'h4, 32'd0, 1, "w1c_status");

    // Auto-reload with PRESCALE=4
    sel4 = 1'b1;
    start_timer(32'd0, 32'd2, 3'b111, 4);
    repeat (6) axi_read(4'h8, 32'd0, 1, "ar_count");
    irq_span(4, "ar_irq");
    axi_write(4'h4, 32'd1, 2);
    m_clr = wr_edge;
    irq_span(16, "ar_irq_rematch");
    axi_read(4'h8, 32'd0, 1, "ar_count_late");

    // Wrap of COUNT at 2^32
    sel4 = 1'b0;
    start_timer(32'hFFFF_FFFE, 32'h10, 3'b001, 1);
    axi_read(4'h8, 32'd0, 1, "wrap_count");
    axi_read(4'h8, 32'd0, 1, "wrap_count2");

    // COUNT load while ticking every cycle: the load wins
    axi_write(4'h8, 32'h100, 2);
    m_start = 32'h100; m_edge = wr_edge;
    axi_read(4'h8, 32'd0, 1, "count_load_tick");

    // W1C landing on the same edge as a new match: match stays set
    start_timer(32'd0, 32'd8, 3'b001, 1);
    begin
      int target;
      target = m_edge + 9;
      while (cyc < target - 2) @(negedge clk);
      axi_write(4'h4, 32'd1, 2);
      check_eq("w1c_align", 32'(wr_edge), 32'(target));
      m_clr = wr_edge;
    end
    axi_read(4'h4, 32'd0, 1, "w1c_vs_set");

    // Reset while a read response is pending
    @(posedge clk); #1;
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
    wait_for(0, "arready_mid");
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_for(1, "rvalid_mid");
    check_eq("rvalid_before_rst", {31'd0, rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rvalid_async_drop", {31'd0, rvalid}, 32'd0);
    check_eq("bvalid_in_rst", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rready = 1'b1;
    axi_read(4'h8, 32'd0, 0, "post_rst_count");
    axi_read(4'h0, 32'd0, 0, "post_rst_ctrl");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
